// File: rtl/rf_pkg.sv
// rf_pkg: shared types and helpers for the multi-port register file.
//   rf_state_t  - sweep FSM state (RF_CLEAR while storage is being zeroed)
//   rf_aw       - address width for an n-entry file
//   rf_addr_ok  - true when an address names a writable/readable entry
package rf_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_IDLE  = 1'b1
    } rf_state_t;

    function automatic int unsigned rf_aw(input int unsigned n);
        return $clog2(n);
    endfunction

    // Entries past NREGS do not exist; entry 0 is hardwired when zero_reg is set.
    function automatic logic rf_addr_ok(input int unsigned a,
                                        input int unsigned nregs,
                                        input int unsigned zero_reg);
        return (a < nregs) && !((zero_reg != 0) && (a == 0));
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: one combinational read port of the register file.
//   state_i            - sweep FSM state; all reads return 0 while clearing
//   addr_i             - read address
//   we*_i/waddr*_i/wdata*_i - write ports, used for same-cycle bypass
//   entry_i            - stored value at addr_i
//   data_o             - read data
module rf_read_port
    import rf_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned AW       = 5
) (
    input  rf_state_t       state_i,
    input  logic [AW-1:0]   addr_i,
    input  logic            we0_i,
    input  logic [AW-1:0]   waddr0_i,
    input  logic [XLEN-1:0] wdata0_i,
    input  logic            we1_i,
    input  logic [AW-1:0]   waddr1_i,
    input  logic [XLEN-1:0] wdata1_i,
    input  logic [XLEN-1:0] entry_i,
    output logic [XLEN-1:0] data_o
);

    logic addr_ok;
    assign addr_ok = rf_addr_ok(32'(addr_i), NREGS, ZERO_REG);

    // A matching write address is legal whenever the read address is, so
    // gating on addr_ok alone keeps ignored writes out of the bypass.
    always_comb begin
        data_o = '0;
        if (state_i == RF_IDLE && addr_ok) begin
            if (we1_i && waddr1_i == addr_i)
                data_o = wdata1_i;
            else if (we0_i && waddr0_i == addr_i)
                data_o = wdata0_i;
            else
                data_o = entry_i;
        end
    end

endmodule

// File: rtl/multiport_reg_file.sv
// multiport_reg_file: integer register file with NRD combinational read
// ports, two write ports (port 1 wins on address collision), write-first
// bypass and an optional hardwired zero entry. Storage is zeroed by a
// one-entry-per-cycle sweep after rst or a soft clear.
//   clk, rst          - clock, synchronous active-high reset
//   clear             - soft clear request (sampled only when ready)
//   ready             - storage valid, writes accepted
//   rd_addr/rd_data   - packed read ports, port i at [i*AW +: AW]/[i*XLEN +: XLEN]
//   we*/waddr*/wdata* - write ports 0 and 1
module multiport_reg_file
    import rf_pkg::*;
#(
    parameter  int unsigned XLEN     = 32,
    parameter  int unsigned NREGS    = 32,
    parameter  int unsigned NRD      = 2,
    parameter  int unsigned ZERO_REG = 1,
    localparam int unsigned AW       = rf_aw(NREGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    output logic                 ready,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*XLEN-1:0]  rd_data,
    input  logic                 we0,
    input  logic                 we1,
    input  logic [AW-1:0]        waddr0,
    input  logic [AW-1:0]        waddr1,
    input  logic [XLEN-1:0]      wdata0,
    input  logic [XLEN-1:0]      wdata1
);

    rf_state_t       state_q;
    logic [AW-1:0]   idx_q;
    logic            ready_q;
    logic [XLEN-1:0] mem_q [NREGS];

    logic wr0_d, wr1_d;
    assign wr0_d = we0 && rf_addr_ok(32'(waddr0), NREGS, ZERO_REG);
    assign wr1_d = we1 && rf_addr_ok(32'(waddr1), NREGS, ZERO_REG);

    // Sweep FSM: one entry zeroed per cycle, ready rises with the last one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RF_CLEAR;
            idx_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                RF_CLEAR: begin
                    if (idx_q == AW'(NREGS - 1)) begin
                        state_q <= RF_IDLE;
                        idx_q   <= '0;
                        ready_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + AW'(1);
                    end
                end
                default: begin
                    if (clear) begin
                        state_q <= RF_CLEAR;
                        idx_q   <= '0;
                        ready_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign ready = ready_q;

    // Storage has no reset; the sweep defines it. Port 1 is written last so
    // it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (state_q == RF_CLEAR) begin
            mem_q[idx_q] <= '0;
        end else if (!rst) begin
            if (wr0_d) mem_q[waddr0] <= wdata0;
            if (wr1_d) mem_q[waddr1] <= wdata1;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] addr;
        assign addr = rd_addr[i*AW +: AW];

        rf_read_port #(
            .XLEN     (XLEN),
            .NREGS    (NREGS),
            .ZERO_REG (ZERO_REG),
            .AW       (AW)
        ) u_port (
            .state_i  (state_q),
            .addr_i   (addr),
            .we0_i    (we0),
            .waddr0_i (waddr0),
            .wdata0_i (wdata0),
            .we1_i    (we1),
            .waddr1_i (waddr1),
            .wdata1_i (wdata1),
            .entry_i  (mem_q[addr]),
            .data_o   (rd_data[i*XLEN +: XLEN])
        );
    end

endmodule

// File: doc/multiport_reg_file.md
# multiport_reg_file

Parametrised multi-port integer register file for the single-cycle/pipelined RISC-V datapath. It has NRD combinational read ports and two synchronous write ports with defined priority, plus same-cycle write-to-read bypass and an optional hardwired zero register. Storage is cleared by a one-entry-per-cycle sweep, triggered by reset or by a soft clear request, and the sweep is visible through `ready`. The block sits between decode (read addresses) and writeback (write ports).

## Interface
- `XLEN`, 32: data width in bits.
- `NREGS`, 32: number of entries. Must be ≥ 2.
- `NRD`, 2: number of read ports. Must be ≥ 1.
- `ZERO_REG`, 1: when 1, entry 0 always reads 0 and ignores writes.
- Derived: `AW = $clog2(NREGS)`.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high; clock clk.
- `clear`  in  1  soft clear request, sampled only in IDLE.
- `ready`  out  1  high when IDLE (storage valid, writes accepted).
- `rd_addr`  in  NRD*AW  read addresses; port i uses bits [i*AW +: AW].
- `rd_data`  out  NRD*XLEN  read data; port i uses bits [i*XLEN +: XLEN].
- `we0`, `we1`  in  1 each  write enables.
- `waddr0`, `waddr1`  in  AW each  write addresses.
- `wdata0`, `wdata1`  in  XLEN each  write data.

## Operation
- States: CLEAR and IDLE.
- Reset (`rst`=1 at an edge): state←CLEAR, sweep index←0, `ready`←0. This applies in any state. A reset mid-sweep restarts the sweep at index 0.
- CLEAR:
  - Each cycle writes 0 to entry[index] and increments index.
  - When index = NREGS-1 is written, the next state is IDLE.
  - `we0`/`we1` and `clear` are ignored.
  - All `rd_data` ports return 0.
- IDLE:
  - `clear`=1 → CLEAR with index←0 on the next edge. Writes presented in that same cycle are still performed.
  - Write port p commits wdata_p to entry[waddr_p] at the edge when we_p=1, subject to the ignore rules below.
  - Both ports enabled to the same address: port 1 wins, port 0 is discarded.
- Ignored writes:
  - Address ≥ NREGS (only possible when NREGS is not a power of two).
  - Address 0 when ZERO_REG=1.
- Read port i is purely combinational from `rd_addr`, state and write inputs:
  - CLEAR → 0.
  - Address ≥ NREGS → 0.
  - Address 0 with ZERO_REG=1 → 0.
  - Else if we1 && waddr1==addr (and the write is legal) → wdata1.
  - Else if we0 && waddr0==addr (and the write is legal) → wdata0.
  - Else → entry[addr].
- Bypass is write-first. Ignored writes never bypass.

## Timing
- Reset values: `ready`=0, state=CLEAR, index=0, all `rd_data`=0.
- Storage contents are undefined until the sweep completes.
- Clear latency: `ready` rises exactly NREGS cycles after the edge that samples `rst` or the IDLE `clear`. The first edge writes entry 0; the NREGS-th edge writes entry NREGS-1 and sets state=IDLE.
- Write latency: commit at the edge. A read of the same address is visible in the same cycle through the bypass, and from storage on the following cycles.
- Read latency: zero cycles (combinational). There is no registered output.
- `clear` held high in IDLE for several cycles starts exactly one sweep. `clear` is re-sampled only after returning to IDLE.
- `rst` and `clear` together: `rst` dominates. The result is the same: sweep restarts at 0.

## Structure
- Shared package `rf_pkg`:
  - `rf_state_t` enum {RF_CLEAR, RF_IDLE}.
  - Function `rf_aw(n)` returning `$clog2(n)`.
- Sub-module `rf_read_port`, instantiated NRD times by generate. It holds the address legality check, two-level bypass priority mux and CLEAR gating.
- The top level holds storage, write logic and the clear FSM.

## Test plan
- Reset with defaults → `ready`=0 for 32 cycles and high on cycle 32. All reads return 0 throughout.
- Write 0xDEADBEEF to r5 via port 0 and read r5 on port 1 in the same cycle → 0xDEADBEEF (bypass). Next cycle, with no write → 0xDEADBEEF.
- Same-cycle we0 (r7, 0x11111111) and we1 (r7, 0x22222222) → read r7 returns 0x22222222 both in that cycle and afterwards.
- Write 0x12345678 to r0 with ZERO_REG=1 → r0 reads 0. Repeat with ZERO_REG=0 → r0 reads 0x12345678.
- Assert `clear` after filling r1..r31; assert `rst` at sweep index 10 → `ready` stays low 32 more cycles. After ready, all entries read 0, and writes issued during CLEAR are not retained.
- NREGS=24, NRD=3: write to address 25 → ignored. Reading address 25 → 0. All three ports independently read distinct registers correctly.
